stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N:1 multiplexer with valid/ready handshake and a registered output stage.
- Generalises the 4:1, 2-bit combinational mux to WIDTH-bit data and NCH channels.
- Two selection modes: fixed (external select) and round-robin arbitration.
- Sits between several producer streams and a single consumer; provides backpressure to each producer.

Parameters:
- WIDTH, 2, data width per channel in bits (>=1).
- NCH, 4, number of input channels (>=2; power of two not required).
- SEL_W, $clog2(NCH), width of the select and channel-id fields. Local, derived; not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel select, used only when mode=0.
- in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; at most one bit high per cycle.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output holds a valid beat.
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (async assert, sync deassert in the surrounding design): out_valid=0, out_data=0, out_ch=0, RR pointer ptr=0. in_ready is combinational and therefore all 0 while out_valid=0 and no grant exists.
- Load enable: ld = !out_valid || out_ready. This is a single register stage and sustains full throughput, 1 beat per cycle.
- Grant, evaluated combinationally every cycle:
  - mode=0: grant=sel and gv=in_valid[sel]. If sel>=NCH, then gv=0 (no grant, no X).
  - mode=1: grant is the first i with in_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo NCH. gv=|in_valid.
- in_ready[i] = ld && gv && (grant==i). A transfer on channel i occurs when in_valid[i] && in_ready[i].
- On a clock edge with ld=1:
  - If gv: out_data<=in_data[grant], out_ch<=grant, out_valid<=1.
  - Else: out_valid<=0, and out_data/out_ch hold.
- On a clock edge with ld=0: all output registers hold. out_data must stay stable while out_valid && !out_ready.
- Latency: accept at edge k, so out_valid=1 with that beat during cycle k+1.
- RR pointer:
  - On a transfer while mode=1: ptr<=(grant==NCH-1) ? 0 : grant+1.
  - No update on a cycle with no transfer, nor in mode=0.
- Mode/sel changes take effect in the same cycle's grant. No beat is lost or duplicated because switching only affects which channel is granted next.
- Simultaneous pop and push (out_valid && out_ready && gv): the new beat replaces the old one in the same edge, with no bubble.
- A producer dropping in_valid without a handshake is tolerated; the grant simply moves on.
- Reset mid-operation: the in-flight output beat is discarded, out_valid drops immediately (async), and ptr returns to 0.

Test Plan:
- Fixed mode, WIDTH=2, NCH=4, in_data={11,10,01,00}, all in_valid=1, out_ready=1, sel stepped 0,1,2,3 every cycle -> out_data 00,01,10,11 with out_ch 0..3 one cycle after each sel. in_ready one-hot matches sel.
- Round-robin, all in_valid=1, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. Each in_ready[i] is high exactly twice.
- Round-robin, only channels 1 and 3 valid -> out_ch alternates 1,3,1,3. Pointer wrap from 3 back to 1 skips idle channels 0 and 2.
- Backpressure: out_ready=0 for 3 cycles after the first beat (ch 2, data 10) -> out_valid stays 1, out_data=10 stable, all in_ready=0. On release, the next beat follows with no bubble.
- Fixed mode with sel=2 and in_valid[2]=0 while other channels are valid -> out_valid falls to 0 and no in_ready is asserted. Setting in_valid[2]=1 produces a beat the next cycle.
- Assert rst_n=0 mid-stream while out_valid=1 -> out_valid, out_data and out_ch are 0 immediately. After release in RR mode with all valid, the first grant is channel 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream multiplexer with a single registered
// output stage. Channel selection is either an external select (mode=0) or a
// round-robin arbiter (mode=1) whose pointer advances past the last served
// channel, so idle channels are skipped without costing a cycle.
module stream_mux_rr #(
    parameter int WIDTH = 2,
    parameter int NCH   = 4,
    localparam int SEL_W = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_ch_q,    out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic             ld;
    logic [SEL_W-1:0] grant;
    logic             gv;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_found;
    logic             fix_gv;
    logic [WIDTH-1:0] mux_data;

    // The output register can take a new beat when empty or being drained.
    assign ld = !out_valid_q || out_ready;

    // Round-robin search starting at ptr, wrapping modulo NCH; first valid wins.
    always_comb begin
        int idx;
        idx      = 0;
        rr_grant = '0;
        rr_found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!rr_found && in_valid[idx]) begin
                rr_found = 1'b1;
                rr_grant = SEL_W'(idx);
            end
        end
    end

    // Fixed-mode valid lookup; a select value with no matching channel never grants.
    always_comb begin
        fix_gv = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SEL_W'(i)) begin
                fix_gv = in_valid[i];
            end
        end
    end

    // Pick the grant source according to mode, then mux the granted channel's data.
    always_comb begin
        grant    = mode ? rr_grant : sel;
        gv       = mode ? rr_found : fix_gv;
        mux_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == SEL_W'(i)) begin
                mux_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Per-channel ready: only the granted channel, and only when the stage can load.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
            assign in_ready[gi] = ld && gv && (grant == SEL_W'(gi));
        end
    endgenerate

    // Next-state for the output stage and the round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (ld) begin
            if (gv) begin
                out_data_d  = mux_data;
                out_ch_d    = grant;
                out_valid_d = 1'b1;
                if (mode) begin
                    ptr_d = (grant == SEL_W'(NCH-1)) ? '0 : grant + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; reset discards any in-flight beat and rewinds the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr: directed vector table plus hand-written reset sequence.
module tb_stream_mux_rr;

    localparam int WIDTH = 2;
    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_ch;
    logic                 out_valid;
    logic                 out_ready;

    int n_vec;
    int n_bad;

    typedef struct packed {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       oready;
        logic [3:0] exp_rdy;
        logic       exp_ov;
        logic [1:0] exp_data;
        logic [1:0] exp_ch;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %b expected %b", name, idx, act, exp);
        end else begin
            $display("ok   %s #%0d: %b", name, idx, act);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // Fixed mode, sel stepped 0..3, data of channel i is i
        vecs[0]  = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
        vecs[1]  = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
        vecs[2]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
        vecs[3]  = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
        // Round-robin, all valid: 0,1,2,3,0,1,2,3 (pointer untouched by fixed mode)
        for (int k = 0; k < 8; k++) begin
            vecs[4+k] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 2'(k % 4)};
        end
        // Round-robin, only channels 1 and 3 valid: idle channels skipped
        vecs[12] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
        vecs[13] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
        vecs[14] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};
        vecs[15] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
        // Fixed sel=2 with channel 2 idle: valid drops, data/ch hold
        vecs[16] = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd3, 2'd3};
        vecs[17] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 2'd2};
        // Backpressure for 3 cycles on the ch2 beat, then release with no bubble
        vecs[18] = '{1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 2'd2};
        vecs[19] = '{1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 2'd2};
        vecs[20] = '{1'b0, 2'd3, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 2'd2};
        vecs[21] = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 2'd3};
        // Round-robin again from pointer 0, advancing it to 2 before the reset
        vecs[22] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 2'd0};
        vecs[23] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 2'd1};

        in_data   = 8'b11_10_01_00;
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '0;
        out_ready = 1'b0;

        #12;
        check("reset_out", -1, {3'b0, out_valid, out_data, out_ch}, 8'h00);
        check("reset_rdy", -1, {4'b0, in_ready}, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            mode      = vecs[i].mode;
            sel       = vecs[i].sel;
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].oready;
            #1;
            check("in_ready", i, {4'b0, in_ready}, {4'b0, vecs[i].exp_rdy});
            @(posedge clk);
            #1;
            check("out", i, {3'b0, out_valid, out_data, out_ch},
                  {3'b0, vecs[i].exp_ov, vecs[i].exp_data, vecs[i].exp_ch});
        end

        // Asynchronous reset mid-cycle while a beat is held
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", 0, {3'b0, out_valid, out_data, out_ch}, 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_out", 0, {3'b0, out_valid, out_data, out_ch}, 8'h00);
        rst_n = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("post_rst_rdy", 0, {4'b0, in_ready}, 8'b0000_0001);
        @(posedge clk);
        #1;
        check("post_rst_out", 0, {3'b0, out_valid, out_data, out_ch}, {3'b0, 1'b1, 2'd0, 2'd0});
        @(posedge clk);
        #1;
        check("post_rst_out", 1, {3'b0, out_valid, out_data, out_ch}, {3'b0, 1'b1, 2'd1, 2'd1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
